// File: rtl/bridge_pulse_sequencer.sv
// bridge_pulse_sequencer
//   Sequencer for the H-bridge transmit pulse generator (Q2Q7/Q4Q5 driver).
//   Keeps the host-written timing word, echo period and echo count. On start
//   it snapshots them into shadow registers. It then loads the timing word
//   into the generator with two load strobes and gates the generator run
//   enable once per echo, for the programmed number of echoes.
//
//   Ports
//     clk, reset     system clock, asynchronous active-low reset
//     cfg_we/addr/   host config write (0=timing word, 1=period, 2=count,
//     cfg_data       3=reserved); accepted only while idle
//     start, abort   one-cycle run request / abort request (abort wins)
//     pulse_datain   timing word to the generator (shadow copy while busy)
//     pulse_load     generator load strobe
//     pulse_en       generator run enable (1 = run)
//     busy, done     run status to the acquisition controller
//     echo_idx       0-based index of the current echo
//     cfg_err        sticky flag: a start was rejected for invalid config
//     phase_sel      (BRIDGE_PHASE_ALT_EN only) leg-swap select, 0,1,0,...
//
//   Optional feature macro: BRIDGE_PHASE_ALT_EN adds the phase_sel output.

module bridge_pulse_sequencer #(
   parameter int CNT_W = 16,
   parameter int NUM_W = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [15:0]      cfg_data,
   input  logic             start,
   input  logic             abort,
   output logic [15:0]      pulse_datain,
   output logic             pulse_load,
   output logic             pulse_en,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] echo_idx,
   output logic             cfg_err
`ifdef BRIDGE_PHASE_ALT_EN
   ,
   output logic             phase_sel
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ARM,
      S_FIRE,
      S_GAP,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [15:0]      word_reg, word_sh;
   logic [CNT_W-1:0] period_reg, period_sh;
   logic [NUM_W-1:0] count_reg, count_sh;
   logic [CNT_W-1:0] cnt;

   // Start validation works on the live config registers.
   logic [3:0]       w1;
   logic [5:0]       w2, w3;
   logic [6:0]       fire_len;
   logic [CNT_W-1:0] min_period;
   logic             cfg_valid;
   logic             start_req;
   logic             accept;

   // Run timing works on the shadow registers.
   logic [CNT_W-1:0] fire_last;
   logic [CNT_W-1:0] period_last;
   logic [NUM_W-1:0] count_last;
   logic             period_end;
   logic             last_echo;

   // Bits of cfg_data above the period/count widths are intentionally unused.
   logic             unused_cfg_bits;

   assign unused_cfg_bits = ^cfg_data;

   assign w1         = word_reg[3:0];
   assign w2         = word_reg[9:4];
   assign w3         = word_reg[15:10];
   assign fire_len   = {1'b0, w3} + 7'd2;
   assign min_period = CNT_W'(fire_len) + CNT_W'(2);
   assign cfg_valid  = (w1 != 4'd0) && ({2'b00, w1} < w2) && (w2 < w3) &&
                       (count_reg != '0) && (period_reg >= min_period);

   // A start arriving together with abort is dropped entirely.
   assign start_req  = start && !abort && (state == S_IDLE);
   assign accept     = start_req && cfg_valid;

   // The counter starts at 0 on the first FIRE cycle, so FIRE ends at w3+1.
   assign fire_last   = CNT_W'({1'b0, word_sh[15:10]} + 7'd1);
   assign period_last = period_sh - CNT_W'(1);
   assign count_last  = count_sh - NUM_W'(1);
   assign period_end  = (cnt == period_last);
   assign last_echo   = (echo_idx == count_last);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: if (accept) state_nxt = S_LOAD;
            S_LOAD: if (cnt[1:0] == 2'd3) state_nxt = S_ARM;
            S_ARM:  state_nxt = S_FIRE;
            S_FIRE: if (cnt == fire_last) state_nxt = S_GAP;
            S_GAP:  if (period_end) state_nxt = last_echo ? S_DONE : S_FIRE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Outputs decoded from the registered state
   always_comb begin
      busy         = (state != S_IDLE);
      done         = (state == S_DONE);
      pulse_en     = (state == S_FIRE);
      // Load strobe in the 1st and 3rd LOAD cycles: the generator latches
      // the timing word through two register stages.
      pulse_load   = (state == S_LOAD) && !cnt[0];
      pulse_datain = (state != S_IDLE) ? word_sh : 16'h0000;
   end

   // Config, shadow and status registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_reg   <= '0;
         period_reg <= '0;
         count_reg  <= '0;
         word_sh    <= '0;
         period_sh  <= '0;
         count_sh   <= '0;
         echo_idx   <= '0;
         cfg_err    <= 1'b0;
      end else begin
         if (cfg_we && (state == S_IDLE)) begin
            unique case (cfg_addr)
               2'd0:    word_reg   <= cfg_data;
               2'd1:    period_reg <= cfg_data[CNT_W-1:0];
               2'd2:    count_reg  <= cfg_data[NUM_W-1:0];
               default: ;
            endcase
         end

         if (start_req && !cfg_valid) begin
            cfg_err <= 1'b1;
         end else if (cfg_we || accept) begin
            cfg_err <= 1'b0;
         end

         if (accept) begin
            word_sh   <= word_reg;
            period_sh <= period_reg;
            count_sh  <= count_reg;
            echo_idx  <= '0;
         end else if (!abort && (state == S_GAP) && period_end && !last_echo) begin
            echo_idx  <= echo_idx + NUM_W'(1);
         end
      end
   end

   // Shared counter: LOAD cycle index, then period position within each echo.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else begin
         unique case (state)
            S_LOAD:  cnt <= cnt + CNT_W'(1);
            S_FIRE:  cnt <= cnt + CNT_W'(1);
            S_GAP:   cnt <= period_end ? '0 : cnt + CNT_W'(1);
            default: cnt <= '0;
         endcase
      end
   end

`ifdef BRIDGE_PHASE_ALT_EN
   // Toggles only on FIRE->GAP, so it never changes while pulse_en is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_sel <= 1'b0;
      end else if (state_nxt == S_IDLE) begin
         phase_sel <= 1'b0;
      end else if ((state == S_FIRE) && (state_nxt == S_GAP)) begin
         phase_sel <= ~phase_sel;
      end
   end
`endif

endmodule

// File: tb/tb_bridge_pulse_sequencer.sv
module tb_bridge_pulse_sequencer;

   localparam int CNT_W = 16;
   localparam int NUM_W = 12;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             cfg_we = 1'b0;
   logic [1:0]       cfg_addr = 2'd0;
   logic [15:0]      cfg_data = 16'h0000;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [15:0]      pulse_datain;
   logic             pulse_load;
   logic             pulse_en;
   logic             busy;
   logic             done;
   logic [NUM_W-1:0] echo_idx;
   logic             cfg_err;
`ifdef BRIDGE_PHASE_ALT_EN
   logic             phase_sel;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bridge_pulse_sequencer #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_data     (cfg_data),
      .start        (start),
      .abort        (abort),
      .pulse_datain (pulse_datain),
      .pulse_load   (pulse_load),
      .pulse_en     (pulse_en),
      .busy         (busy),
      .done         (done),
      .echo_idx     (echo_idx),
      .cfg_err      (cfg_err)
`ifdef BRIDGE_PHASE_ALT_EN
      ,
      .phase_sel    (phase_sel)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      tick;
      cfg_we   = 1'b0;
   endtask

   // Echo whose FIRE window contains cycle c, or -1 (FIRE_LEN = fl).
   function automatic int fire_echo(input int c, input int p, input int n, input int fl);
      for (int k = 0; k < n; k++)
         if (c >= 6 + k * p && c < 6 + k * p + fl) return k;
      return -1;
   endfunction

   // Run with timing word 0x50A3 (FIRE_LEN 22). Start sampled at cycle 0.
   // abort_c/wr_c/st_c < 0 disables abort, ignored period write, busy start.
   task automatic run_seq(input string tag, input int p, input int n, input int abort_c,
                          input int last_c, input int wr_c, input int st_c);
      int done_c;
      int k;
      bit live;
      done_c = 6 + n * p;
      start = 1'b1;
      chk($sformatf("%s_busy_c0", tag), 32'(busy), 32'(0));
      tick;
      start = 1'b0;
      for (int c = 1; c <= last_c; c++) begin
         live = (abort_c < 0) || (c <= abort_c);
         k    = fire_echo(c, p, n, 22);
         chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(live && c <= done_c));
         chk($sformatf("%s_load_c%0d", tag, c), 32'(pulse_load), 32'(live && (c == 1 || c == 3)));
         chk($sformatf("%s_en_c%0d", tag, c), 32'(pulse_en), 32'(live && k >= 0));
         chk($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(live && c == done_c));
         chk($sformatf("%s_data_c%0d", tag, c), 32'(pulse_datain),
             (live && c <= done_c) ? 32'h50A3 : 32'h0);
         if (live && k >= 0) begin
            chk($sformatf("%s_idx_c%0d", tag, c), 32'(echo_idx), 32'(k));
`ifdef BRIDGE_PHASE_ALT_EN
            chk($sformatf("%s_phase_c%0d", tag, c), 32'(phase_sel), 32'(k % 2));
`endif
         end
         if (c == abort_c) abort = 1'b1;
         if (c == st_c) start = 1'b1;
         if (c == wr_c) begin
            cfg_we   = 1'b1;
            cfg_addr = 2'd1;
            cfg_data = 16'd100;
         end
         tick;
         abort  = 1'b0;
         start  = 1'b0;
         cfg_we = 1'b0;
      end
   endtask

   initial begin
      // Reset state
      repeat (2) tick;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_en", 32'(pulse_en), 32'(0));
      chk("rst_load", 32'(pulse_load), 32'(0));
      chk("rst_data", 32'(pulse_datain), 32'(0));
      chk("rst_idx", 32'(echo_idx), 32'(0));
      chk("rst_err", 32'(cfg_err), 32'(0));
      #3 reset = 1'b1;
      tick;

      // Full run: period 40, 3 echoes; a start during busy (cycle 10) and a
      // period write during busy (cycle 30) must both be ignored.
      cfg_write(2'd0, 16'h50A3);
      cfg_write(2'd1, 16'd40);
      cfg_write(2'd2, 16'd3);
      run_seq("runA", 40, 3, -1, 130, 30, 10);
      chk("runA_idx_end", 32'(echo_idx), 32'(2));

      // Still period 40 (busy write ignored); abort at cycle 50.
      run_seq("runC", 40, 3, 50, 90, -1, -1);

      // Period written in idle takes effect; abort at cycle 110.
      cfg_write(2'd1, 16'd100);
      run_seq("runB", 100, 3, 110, 140, -1, -1);

      // Period 23 < FIRE_LEN+2: rejected.
      cfg_write(2'd1, 16'd23);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("inv_p23_err", 32'(cfg_err), 32'(1));
      for (int i = 0; i < 6; i++) begin
         chk("inv_p23_busy", 32'(busy), 32'(0));
         chk("inv_p23_en", 32'(pulse_en), 32'(0));
         chk("inv_p23_load", 32'(pulse_load), 32'(0));
         tick;
      end
      cfg_write(2'd3, 16'hFFFF);
      chk("err_clr_cfgwe", 32'(cfg_err), 32'(0));

      // Period exactly FIRE_LEN+2 is valid.
      cfg_write(2'd1, 16'd24);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("p24_busy", 32'(busy), 32'(1));
      chk("p24_load", 32'(pulse_load), 32'(1));
      chk("p24_err", 32'(cfg_err), 32'(0));
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("p24_abort_busy", 32'(busy), 32'(0));

      // count = 0 rejected
      cfg_write(2'd2, 16'd0);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("cnt0_err", 32'(cfg_err), 32'(1));
      chk("cnt0_busy", 32'(busy), 32'(0));
      cfg_write(2'd2, 16'd3);
      chk("cnt3_err_clr", 32'(cfg_err), 32'(0));

      // w1 == w2 rejected
      cfg_write(2'd0, 16'h5033);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("w1eqw2_err", 32'(cfg_err), 32'(1));
      chk("w1eqw2_busy", 32'(busy), 32'(0));
      cfg_write(2'd0, 16'h50A3);
      cfg_write(2'd1, 16'd40);

      // start together with abort in idle: dropped
      start = 1'b1;
      abort = 1'b1;
      tick;
      start = 1'b0;
      abort = 1'b0;
      chk("sa_busy", 32'(busy), 32'(0));
      chk("sa_load", 32'(pulse_load), 32'(0));
      chk("sa_err", 32'(cfg_err), 32'(0));
      tick;
      chk("sa_busy2", 32'(busy), 32'(0));

      // Reset asserted mid-run at cycle 60 (echo 1 FIRE)
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 1; c < 60; c++) tick;
      chk("mid_en_c60", 32'(pulse_en), 32'(1));
      chk("mid_idx_c60", 32'(echo_idx), 32'(1));
      #2 reset = 1'b0;
      #1;
      chk("arst_en", 32'(pulse_en), 32'(0));
      chk("arst_busy", 32'(busy), 32'(0));
      chk("arst_data", 32'(pulse_datain), 32'(0));
      chk("arst_idx", 32'(echo_idx), 32'(0));
      chk("arst_load", 32'(pulse_load), 32'(0));
      #2 reset = 1'b1;
      tick;
      chk("post_rst_busy", 32'(busy), 32'(0));
      chk("post_rst_err", 32'(cfg_err), 32'(0));
      chk("post_rst_en", 32'(pulse_en), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
